binary_to_rns_converter: RTL and testbench

- Forward converter: takes a binary integer X and produces its residues for the moduli set {2^N-1, 2^N+1, 2^(2N)+1, 2^(2N+P)}.
- Companion to the RNS-to-binary reverse converter; it feeds RNS arithmetic channels whose results return through that converter.
- Iterative: folds one N-bit chunk of X per cycle.
- Valid/ready handshake on both input and output sides.

---
 rtl/rns_pkg.sv | 42 ++++
 rtl/mod_fold_acc.sv | 39 +++
 rtl/binary_to_rns_converter.sv | 166 ++++++++++++++++
 tb/tb_binary_to_rns_converter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared definitions for the binary-to-RNS forward converter:
// residue widths per modulus, operand/fold-count derivations and FSM states.
package rns_pkg;

  // Converter control states; IDLE accepts, FOLD consumes one chunk per cycle,
  // FINAL normalises and registers residues, DONE presents them.
  typedef enum logic [1:0] {IDLE, FOLD, FINAL, DONE} state_e;

  // Chunk index width; the fold count is always 6 or 7.
  localparam int IDX_W = 3;

  // Residue width for modulus 2^N-1.
  function automatic int r1_width(input int n);
    return n;
  endfunction

  // Residue width for modulus 2^N+1 (value range 0..2^N).
  function automatic int r2_width(input int n);
    return n + 1;
  endfunction

  // Residue width for modulus 2^(2N)+1 (value range 0..2^(2N)).
  function automatic int r3_width(input int n);
    return 2 * n + 1;
  endfunction

  // Residue width for modulus 2^(2N+P).
  function automatic int r4_width(input int n, input int p);
    return 2 * n + p;
  endfunction

  // Operand width covering the full dynamic range.
  function automatic int x_width(input int n, input int p);
    return 6 * n + p;
  endfunction

  // Number of N-bit chunks needed to cover the operand.
  function automatic int fold_count(input int n, input int p);
    return (6 * n + p + n - 1) / n;
  endfunction

endpackage

// File: rtl/mod_fold_acc.sv
// One modular accumulate step: sum_o = (acc_i +/- addend_i) mod m.
// PLUS=0 selects m = 2^KW-1 (KW-bit operands, end-around carry, all-ones
// allowed as an alias of zero). PLUS=1 selects m = 2^KW+1 (KW+1-bit operands
// kept in [0, 2^KW]); subtraction adds (m - addend).
module mod_fold_acc #(
  parameter int PLUS = 0,
  parameter int KW   = 4
) (
  input  logic [KW+PLUS-1:0] acc_i,
  input  logic [KW+PLUS-1:0] addend_i,
  input  logic               sub_i,
  output logic [KW+PLUS-1:0] sum_o
);

  if (PLUS != 0) begin : g_plus
    localparam logic [KW+1:0] MOD = (KW+2)'((64'd1 << KW) + 64'd1);
    logic [KW+1:0] add_ext;
    logic [KW+1:0] sum;

    // Diminished-free 2^KW+1 add: one conditional subtract brings sum back in range.
    always_comb begin
      add_ext = {1'b0, addend_i};
      if (sub_i) add_ext = MOD - {1'b0, addend_i};
      sum   = {1'b0, acc_i} + add_ext;
      sum_o = (sum >= MOD) ? (KW+1)'(sum - MOD) : sum[KW:0];
    end
  end else begin : g_minus
    logic [KW-1:0] add_eff;
    logic [KW:0]   sum;

    // 2^KW-1 add: negation is bitwise inversion, carry wraps back into bit 0.
    always_comb begin
      add_eff = sub_i ? ~addend_i : addend_i;
      sum     = {1'b0, acc_i} + {1'b0, add_eff};
      sum_o   = sum[KW-1:0] + {{(KW-1){1'b0}}, sum[KW]};
    end
  end

endmodule

// File: rtl/binary_to_rns_converter.sv
// Iterative binary-to-RNS forward converter for moduli
// {2^N-1, 2^N+1, 2^(2N)+1, 2^(2N+P)}, folding one N-bit chunk per cycle.
// Optional macro RNS_RANGE_CHECK_EN adds out_range_err (X >= M).
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; valid never depends on ready, and the DUT keeps outputs stable
// while out_valid && !out_ready. dbg_state exposes the FSM state.
module binary_to_rns_converter
  import rns_pkg::*;
#(
  parameter int N = 4,
  parameter int P = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [x_width(N,P)-1:0]   X,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [r1_width(N)-1:0]    R1,
  output logic [r2_width(N)-1:0]    R2,
  output logic [r3_width(N)-1:0]    R3,
  output logic [r4_width(N,P)-1:0]  R4,
  output logic                      out_range_err,
  output state_e                    dbg_state
);

  localparam int K   = fold_count(N, P);
  localparam int XW  = K * N;
  localparam int R4W = r4_width(N, P);

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     acc1_q, acc1_d, acc1_sum;
  logic [N:0]       acc2_q, acc2_d, acc2_sum;
  logic [2*N:0]     acc3_q, acc3_d, acc3_sum, acc3_addend;
  logic [N-1:0]     r1_q, r1_d;
  logic [N:0]       r2_q, r2_d;
  logic [2*N:0]     r3_q, r3_d;
  logic [R4W-1:0]   r4_q, r4_d;
  logic [N-1:0]     chunk;
`ifdef RNS_RANGE_CHECK_EN
  logic             err_q, err_d;
`endif

  // The latched operand is shifted right each fold, so the current chunk is the low N bits.
  assign chunk = x_q[N-1:0];
  // Odd chunks of the 2^(2N)+1 fold carry weight 2^N.
  assign acc3_addend = idx_q[0] ? {1'b0, chunk, {N{1'b0}}} : {{(N+1){1'b0}}, chunk};

  mod_fold_acc #(.PLUS(0), .KW(N)) u_acc1 (
    .acc_i(acc1_q), .addend_i(chunk), .sub_i(1'b0), .sum_o(acc1_sum)
  );
  mod_fold_acc #(.PLUS(1), .KW(N)) u_acc2 (
    .acc_i(acc2_q), .addend_i({1'b0, chunk}), .sub_i(idx_q[0]), .sum_o(acc2_sum)
  );
  mod_fold_acc #(.PLUS(1), .KW(2*N)) u_acc3 (
    .acc_i(acc3_q), .addend_i(acc3_addend), .sub_i(idx_q[1]), .sum_o(acc3_sum)
  );

  // Next-state and handshake outputs for the IDLE/FOLD/FINAL/DONE sequence.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    idx_d     = idx_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    acc3_d    = acc3_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    r3_d      = r3_q;
    r4_d      = r4_q;
`ifdef RNS_RANGE_CHECK_EN
    err_d     = err_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = XW'(X);
          r4_d    = X[R4W-1:0];
          acc1_d  = '0;
          acc2_d  = '0;
          acc3_d  = '0;
          idx_d   = '0;
`ifdef RNS_RANGE_CHECK_EN
          err_d   = (X[x_width(N,P)-1 -: 4*N] == '1);
`endif
          state_d = FOLD;
        end
      end
      FOLD: begin
        acc1_d = acc1_sum;
        acc2_d = acc2_sum;
        acc3_d = acc3_sum;
        x_d    = x_q >> N;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IDX_W'(K - 1)) state_d = FINAL;
      end
      FINAL: begin
        r1_d    = (acc1_q == '1) ? '0 : acc1_q;
        r2_d    = acc2_q;
        r3_d    = acc3_q;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef RNS_RANGE_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      idx_q   <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      acc3_q  <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      r4_q    <= '0;
`ifdef RNS_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      acc3_q  <= acc3_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      r4_q    <= r4_d;
`ifdef RNS_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign R1        = r1_q;
  assign R2        = r2_q;
  assign R3        = r3_q;
  assign R4        = r4_q;
  assign dbg_state = state_q;
`ifdef RNS_RANGE_CHECK_EN
  assign out_range_err = err_q;
`else
  assign out_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_rns_converter.sv
// Self-checking bench for binary_to_rns_converter: instance A (N=2,P=0)
// for directed and random vectors, instance B (N=4,P=2) for a random sweep.
module tb_binary_to_rns_converter;
  import rns_pkg::*;

  localparam int NA = 2, PA = 0, WA = 12;
  localparam int NB = 4, PB = 2, WB = 26;
  localparam int EW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic          in_valid_a = 1'b0, out_ready_a = 1'b1;
  logic          in_ready_a, out_valid_a, err_a;
  logic [WA-1:0] x_a = '0;
  logic [1:0]    r1_a;
  logic [2:0]    r2_a;
  logic [4:0]    r3_a;
  logic [3:0]    r4_a;
  state_e        dbg_a;

  binary_to_rns_converter #(.N(NA), .P(PA)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .X(x_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .R1(r1_a), .R2(r2_a),
    .R3(r3_a), .R4(r4_a), .out_range_err(err_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B ----------------
  logic          in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic          in_ready_b, out_valid_b, err_b;
  logic [WB-1:0] x_b = '0;
  logic [3:0]    r1_b;
  logic [4:0]    r2_b;
  logic [8:0]    r3_b;
  logic [9:0]    r4_b;
  state_e        dbg_b;

  binary_to_rns_converter #(.N(NB), .P(PB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .X(x_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .R1(r1_b), .R2(r2_b),
    .R3(r3_b), .R4(r4_b), .out_range_err(err_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  logic [EW-1:0] ea, eb;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected word layout: err[60], r1[59:48], r2[47:32], r3[31:16], r4[15:0].
  function automatic logic [63:0] pack(input logic e, input logic [63:0] r1,
                                       input logic [63:0] r2, input logic [63:0] r3,
                                       input logic [63:0] r4);
    return {3'b000, e, r1[11:0], r2[15:0], r3[15:0], r4[15:0]};
  endfunction

  function automatic logic range_a(input logic [63:0] x);
    logic r;
    r = (x >= 64'd4080);
`ifndef RNS_RANGE_CHECK_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  // Reference: plain integer remainders against each modulus.
  function automatic logic [63:0] model(input int n, input int p, input logic [63:0] x);
    logic [63:0] m1, m2, m3, m4, mr;
    logic e;
    m1 = (64'd1 << n) - 64'd1;
    m2 = (64'd1 << n) + 64'd1;
    m3 = (64'd1 << (2 * n)) + 64'd1;
    m4 = 64'd1 << (2 * n + p);
    mr = ((64'd1 << (4 * n)) - 64'd1) * m4;
    e  = (x >= mr);
`ifndef RNS_RANGE_CHECK_EN
    e  = 1'b0;
`endif
    return pack(e, x % m1, x % m2, x % m3, x % m4);
  endfunction

  // Output monitors: compare on every completed output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) check("unexpected_out_a", 1, 0);
      else begin
        ea = exp_a.pop_front();
        check("r1_a", 64'(r1_a), 64'(ea[59:48]));
        check("r2_a", 64'(r2_a), 64'(ea[47:32]));
        check("r3_a", 64'(r3_a), 64'(ea[31:16]));
        check("r4_a", 64'(r4_a), 64'(ea[15:0]));
        check("err_a", 64'(err_a), 64'(ea[60]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) check("unexpected_out_b", 1, 0);
      else begin
        eb = exp_b.pop_front();
        check("r1_b", 64'(r1_b), 64'(eb[59:48]));
        check("r2_b", 64'(r2_b), 64'(eb[47:32]));
        check("r3_b", 64'(r3_b), 64'(eb[31:16]));
        check("r4_b", 64'(r4_b), 64'(eb[15:0]));
        check("err_b", 64'(err_b), 64'(eb[60]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1ns after a rising edge.
  task automatic send_a(input logic [WA-1:0] x, input logic [EW-1:0] e);
    int cnt = 0;
    x_a = x;
    in_valid_a = 1'b1;
    exp_a.push_back(e);
    while (!in_ready_a && cnt < 200) begin @(posedge clk); #1; cnt++; end
    if (!in_ready_a) check("in_ready_timeout_a", 0, 1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [WB-1:0] x, input logic [EW-1:0] e);
    int cnt = 0;
    x_b = x;
    in_valid_b = 1'b1;
    exp_b.push_back(e);
    while (!in_ready_b && cnt < 200) begin @(posedge clk); #1; cnt++; end
    if (!in_ready_b) check("in_ready_timeout_b", 0, 1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
  endtask

  task automatic drain_a();
    int cnt = 0;
    while (exp_a.size() != 0 && cnt < 500) begin @(posedge clk); #1; cnt++; end
    check("drain_a", 64'(exp_a.size()), 0);
    exp_a.delete();
  endtask

  task automatic drain_b();
    int cnt = 0;
    while (exp_b.size() != 0 && cnt < 500) begin @(posedge clk); #1; cnt++; end
    check("drain_b", 64'(exp_b.size()), 0);
    exp_b.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int cnt;
    logic [WA-1:0] xa;
    logic [WB-1:0] xb;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready", 64'(in_ready_a), 1);
    check("rst_out_valid", 64'(out_valid_a), 0);
    check("rst_r1", 64'(r1_a), 0);
    check("rst_r2", 64'(r2_a), 0);
    check("rst_r3", 64'(r3_a), 0);
    check("rst_r4", 64'(r4_a), 0);
    check("rst_err", 64'(err_a), 0);
    check("rst_state", 64'(dbg_a), 64'(IDLE));

    // X=100: residues (1,0,15,4), out_valid K+1 = 7 cycles after accept.
    send_a(12'd100, pack(range_a(100), 1, 0, 15, 4));
    lat = 0;
    while (!out_valid_a && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency", 64'(lat), 7);
    drain_a();

    // Boundary operands.
    send_a(12'd0,    pack(range_a(0),    0, 0, 0,  0));
    send_a(12'd4079, pack(range_a(4079), 2, 4, 16, 15));
    send_a(12'd4095, pack(range_a(4095), 0, 0, 15, 15));
    drain_a();

    // Back-pressure: first result held, second operand waits with in_valid high.
    out_ready_a = 1'b0;
    send_a(12'd100, pack(range_a(100), 1, 0, 15, 4));
    cnt = 0;
    while (!out_valid_a && cnt < 50) begin @(posedge clk); #1; cnt++; end
    x_a = 12'd4079;
    in_valid_a = 1'b1;
    exp_a.push_back(pack(range_a(4079), 2, 4, 16, 15));
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(out_valid_a), 1);
      check("hold_in_ready", 64'(in_ready_a), 0);
      check("hold_r1", 64'(r1_a), 1);
      check("hold_r2", 64'(r2_a), 0);
      check("hold_r3", 64'(r3_a), 15);
      check("hold_r4", 64'(r4_a), 4);
      @(posedge clk); #1;
    end
    out_ready_a = 1'b1;
    cnt = 0;
    while (!in_ready_a && cnt < 50) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    drain_a();

    // Reset in the middle of FOLD discards the conversion.
    send_a(12'd4079, pack(range_a(4079), 2, 4, 16, 15));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    check("midrst_in_ready", 64'(in_ready_a), 1);
    check("midrst_out_valid", 64'(out_valid_a), 0);
    check("midrst_state", 64'(dbg_a), 64'(IDLE));
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_a) cnt++;
      @(posedge clk); #1;
    end
    check("midrst_no_output", 64'(cnt), 0);
    send_a(12'd100, pack(range_a(100), 1, 0, 15, 4));
    drain_a();

    // Random sweep, N=2 P=0.
    for (int i = 0; i < 60; i++) begin
      xa = 12'($urandom_range(0, 4095));
      send_a(xa, model(NA, PA, 64'(xa)));
    end
    drain_a();

    // Random sweep, N=4 P=2, including range-limit operands.
    send_b('1, model(NB, PB, 64'({WB{1'b1}})));
    send_b('0, model(NB, PB, 64'd0));
    for (int i = 0; i < 60; i++) begin
      xb = WB'($urandom);
      if (i % 8 == 0) xb[WB-1 -: 16] = '1;
      send_b(xb, model(NB, PB, 64'(xb)));
    end
    drain_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
